serial_b2_subtractor: RTL and testbench

//   Nibble-serial multi-digit base-2 subtractor: computes X - Y - bin on
//   4*NIBBLES-bit operands, one 4-bit digit per clock, least significant

---
 rtl/serial_b2_subtractor.sv | 119 +++++++++++
 tb/tb_serial_b2_subtractor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/serial_b2_subtractor.sv
// Nibble-serial base-2 subtractor: computes X - Y - bin over NIBBLES 4-bit digits,
// least significant digit first, with the inter-digit borrow held in a flip-flop.

module n4_b2_subtractor (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       bin_i,
    output logic [3:0] d_o,
    output logic       bout_o
);
    logic brw;

    // NOTE: blocking assignments are right here because brw is a ripple
    // temporary read back within the same pass; every output gets a default first.
    always_comb begin
        brw = bin_i;
        d_o = '0;
        for (int i = 0; i < 4; i++) begin
            d_o[i] = a_i[i] ^ b_i[i] ^ brw;
            brw    = (~a_i[i] & b_i[i]) | (~(a_i[i] ^ b_i[i]) & brw);
        end
        bout_o = brw;
    end
endmodule

module serial_b2_subtractor #(
    parameter int NIBBLES = 4
) (
    input  logic                   clock,
    input  logic                   reset_,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   x,
    input  logic [4*NIBBLES-1:0]   y,
    input  logic                   bin,
    output logic                   ready,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   d,
    output logic                   bout
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e         state_q;
    logic [W-1:0]   x_q, y_q, res_q, d_q;
    logic [CW-1:0]  cnt_q;
    logic           brw_q, ready_q, done_q, bout_q;

    logic [3:0]     stage_d;
    logic           stage_bout;
    logic [W-1:0]   res_d;

    n4_b2_subtractor u_stage (
        .a_i    (x_q[3:0]),
        .b_i    (y_q[3:0]),
        .bin_i  (brw_q),
        .d_o    (stage_d),
        .bout_o (stage_bout)
    );

    // Result fills from the top so the first digit lands in bits [3:0] after NIBBLES shifts.
    assign res_d = {stage_d, res_q[W-1:4]};

    // NOTE: all state here is sequential, so non-blocking only; the asynchronous
    // reset clears every register, including the operand and result shift regs.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        x_q     <= x;
                        y_q     <= y;
                        brw_q   <= bin;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    res_q <= res_d;
                    x_q   <= x_q >> 4;
                    y_q   <= y_q >> 4;
                    brw_q <= stage_bout;
                    if (cnt_q == LAST) begin
                        d_q     <= res_d;
                        bout_q  <= stage_bout;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready = ready_q;
    assign done  = done_q;
    assign d     = d_q;
    assign bout  = bout_q;
endmodule

// File: tb/tb_serial_b2_subtractor.sv
// Directed bench for serial_b2_subtractor (NIBBLES=4): vector table plus
// hand-written sequences for mid-run start, back-to-back restart and reset.

module tb_serial_b2_subtractor;
    logic        clock = 1'b0;
    logic        reset_;
    logic        start;
    logic [15:0] x, y;
    logic        bin;
    logic        ready, done, bout;
    logic [15:0] d;

    int n_tests = 0;
    int n_fail  = 0;

    serial_b2_subtractor #(.NIBBLES(4)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .start  (start),
        .x      (x),
        .y      (y),
        .bin    (bin),
        .ready  (ready),
        .done   (done),
        .d      (d),
        .bout   (bout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        bin;
        logic [15:0] d;
        logic        bout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a request at a negedge and return at the negedge after the accepting edge.
    task automatic launch(input logic [15:0] xv, input logic [15:0] yv, input logic bv);
        start = 1'b1;
        x     = xv;
        y     = yv;
        bin   = bv;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        x     = 16'hDEAD;
        y     = 16'hBEEF;
        bin   = 1'b1;
    endtask

    // Count edges until done, noting whether ready ever rose early.
    task automatic wait_done(output int lat, output logic ready_seen);
        lat = 0;
        ready_seen = 1'b0;
        while (!done && lat < 20) begin
            if (ready) ready_seen = 1'b1;
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
    endtask

    initial begin
        int   lat;
        logic rs;

        vecs[0] = '{16'h1234, 16'h0123, 1'b0, 16'h1111, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
        vecs[2] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0};
        vecs[5] = '{16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0};
        vecs[6] = '{16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b1};
        vecs[7] = '{16'h7FFF, 16'h7FFF, 1'b0, 16'h0000, 1'b0};

        reset_ = 1'b0;
        start  = 1'b0;
        x      = '0;
        y      = '0;
        bin    = 1'b0;
        #12;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done",  32'(done),  32'd0);
        check("rst_d",     32'(d),     32'd0);
        check("rst_bout",  32'(bout),  32'd0);
        @(negedge clock);
        reset_ = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].x, vecs[i].y, vecs[i].bin);
            check($sformatf("v%0d_busy", i), 32'(ready), 32'd0);
            wait_done(lat, rs);
            check($sformatf("v%0d_lat", i),  32'(lat), 32'd4);
            check($sformatf("v%0d_rdy", i),  32'(rs),  32'd0);
            check($sformatf("v%0d_d", i),    32'(d),    32'(vecs[i].d));
            check($sformatf("v%0d_bout", i), 32'(bout), 32'(vecs[i].bout));
            check($sformatf("v%0d_dn_rdy", i), 32'(ready), 32'd1);
            @(posedge clock);
            @(negedge clock);
            check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
            check($sformatf("v%0d_hold_d", i), 32'(d), 32'(vecs[i].d));
        end

        // start pulsed mid-run is ignored
        launch(16'h1234, 16'h0123, 1'b0);
        @(posedge clock);
        @(negedge clock);
        start = 1'b1;
        x     = 16'hFFFF;
        y     = 16'h0000;
        bin   = 1'b0;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check("ign_ready", 32'(ready), 32'd0);
        wait_done(lat, rs);
        check("ign_lat",  32'(lat), 32'd2);
        check("ign_rdy",  32'(rs),  32'd0);
        check("ign_d",    32'(d),    32'h1111);
        check("ign_bout", 32'(bout), 32'd0);
        repeat (6) @(negedge clock);
        check("ign_idle_ready", 32'(ready), 32'd1);
        check("ign_idle_d",     32'(d),     32'h1111);

        // back-to-back: start held during the DONE cycle restarts immediately
        launch(16'h1234, 16'h0123, 1'b0);
        wait_done(lat, rs);
        check("b2b_first_d", 32'(d), 32'h1111);
        launch(16'h0005, 16'h0007, 1'b0);
        check("b2b_restart_busy", 32'(ready), 32'd0);
        check("b2b_hold_d",       32'(d),     32'h1111);
        wait_done(lat, rs);
        check("b2b_lat",  32'(lat), 32'd4);
        check("b2b_d",    32'(d),    32'hFFFE);
        check("b2b_bout", 32'(bout), 32'd1);

        // async reset two cycles into RUN discards the operation
        @(negedge clock);
        launch(16'h1234, 16'h0123, 1'b0);
        @(posedge clock);
        @(negedge clock);
        reset_ = 1'b0;
        #1;
        check("mid_rst_ready", 32'(ready), 32'd1);
        check("mid_rst_done",  32'(done),  32'd0);
        check("mid_rst_d",     32'(d),     32'd0);
        check("mid_rst_bout",  32'(bout),  32'd0);
        @(negedge clock);
        reset_ = 1'b1;
        @(negedge clock);
        launch(16'h0000, 16'h0001, 1'b0);
        wait_done(lat, rs);
        check("post_rst_lat",  32'(lat), 32'd4);
        check("post_rst_d",    32'(d),    32'hFFFF);
        check("post_rst_bout", 32'(bout), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
